// File: rtl/rf_writeback_queue_if.sv
// Producer handshakes, register-file write port and hazard-lookup signals of rf_writeback_queue.
// The queue takes the slave modport; producers and the register file sit on the master side.
interface rf_writeback_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_reg;
    logic [DW-1:0] mem_data;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_reg;
    logic [DW-1:0] alu_data;
    logic [AW-1:0] DstReg;
    logic          WriteReg;
    logic [DW-1:0] DstData;
    logic [CW-1:0] count;
    logic [AW-1:0] chk_reg;
    logic          chk_pending;
    logic [DW-1:0] chk_data;

    modport master (
        output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, chk_reg,
        input  mem_ready, alu_ready, DstReg, WriteReg, DstData, count, chk_pending, chk_data
    );

    modport slave (
        input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, chk_reg,
        output mem_ready, alu_ready, DstReg, WriteReg, DstData, count, chk_pending, chk_data
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: merges load and ALU results into a FIFO draining one write/cycle.
// Optional pending-write lookup is enabled by defining RF_PEND_LOOKUP_EN.
module rf_writeback_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    rf_writeback_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] reg_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] alu_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   free;
    logic          not_empty;
    logic          mem_push;
    logic          alu_push;

    // The head always drains this cycle, so its slot is already counted as free.
    assign not_empty = (cnt_q != '0);
    assign free      = (CW+1)'(DEPTH) - {1'b0, cnt_q} + {{CW{1'b0}}, not_empty};

    assign bus.mem_ready = (free >= (CW+1)'(1));
    assign bus.alu_ready = (free >= (bus.mem_valid ? (CW+1)'(2) : (CW+1)'(1)));

    // Register-0 writes complete the handshake but never occupy a slot.
    assign mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_reg != '0);
    assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_reg != '0);

    always_comb begin
        alu_idx  = wr_ptr_q + PW'(mem_push);
        wr_ptr_d = wr_ptr_q + PW'(mem_push) + PW'(alu_push);
        rd_ptr_d = rd_ptr_q + PW'(not_empty);
        cnt_d    = cnt_q + CW'(mem_push) + CW'(alu_push) - CW'(not_empty);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (mem_push) begin
                reg_q[wr_ptr_q]  <= bus.mem_reg;
                data_q[wr_ptr_q] <= bus.mem_data;
            end
            if (alu_push) begin
                reg_q[alu_idx]  <= bus.alu_reg;
                data_q[alu_idx] <= bus.alu_data;
            end
        end
    end

    assign bus.WriteReg = not_empty;
    assign bus.DstReg   = not_empty ? reg_q[rd_ptr_q] : '0;
    assign bus.DstData  = not_empty ? data_q[rd_ptr_q] : '0;
    assign bus.count    = cnt_q;

`ifdef RF_PEND_LOOKUP_EN
    logic [PW-1:0] lk_idx;

    // Walk oldest to newest so the last match left standing is the newest queued value.
    always_comb begin
        bus.chk_pending = 1'b0;
        bus.chk_data    = '0;
        lk_idx          = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            lk_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < cnt_q) && (bus.chk_reg != '0) && (reg_q[lk_idx] == bus.chk_reg)) begin
                bus.chk_pending = 1'b1;
                bus.chk_data    = data_q[lk_idx];
            end
        end
    end
`else
    logic unused_chk_reg;

    assign unused_chk_reg  = ^bus.chk_reg;
    assign bus.chk_pending = 1'b0;
    assign bus.chk_data    = '0;
`endif
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed self-checking bench for rf_writeback_queue with a register-file model on the write port.
module tb_rf_writeback_queue;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] rf [16];

    rf_writeback_queue_if #(.DEPTH(4), .DW(16), .AW(4)) bus ();

    rf_writeback_queue #(.DEPTH(4), .DW(16), .AW(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (bus.WriteReg) rf[bus.DstReg] <= bus.DstData;

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle_inputs();
        bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
        checks++; if (bus.WriteReg !== 1'b0) begin errors++;
            $display("FAIL reset_wr: got %0b want 0", bus.WriteReg); end
        checks++; if (bus.count !== 3'd0) begin errors++;
            $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready: got mem=%0b alu=%0b want 1/1", bus.mem_ready, bus.alu_ready); end
        checks++; if (bus.DstReg !== 4'd0 || bus.DstData !== 16'h0) begin errors++;
            $display("FAIL reset_dst: got reg=%0d data=%h want 0/0000", bus.DstReg, bus.DstData); end
    endtask

    task automatic test_single_alu();
        bus.alu_valid = 1'b1; bus.alu_reg = 4'd3; bus.alu_data = 16'h1234;
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd3 || bus.DstData !== 16'h1234) begin
            errors++; $display("FAIL single_head: got wr=%0b reg=%0d data=%h want 1/3/1234",
                               bus.WriteReg, bus.DstReg, bus.DstData); end
        tick();
        checks++; if (bus.WriteReg !== 1'b0) begin errors++;
            $display("FAIL single_done: got wr=%0b want 0", bus.WriteReg); end
        checks++; if (rf[3] !== 16'h1234) begin errors++;
            $display("FAIL single_rf: got R3=%h want 1234", rf[3]); end
    endtask

    task automatic test_collision();
        bus.mem_valid = 1'b1; bus.mem_reg = 4'd5; bus.mem_data = 16'hAAAA;
        bus.alu_valid = 1'b1; bus.alu_reg = 4'd5; bus.alu_data = 16'h5555;
        #1;
        checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin errors++;
            $display("FAIL coll_ready: got mem=%0b alu=%0b want 1/1", bus.mem_ready, bus.alu_ready); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.count !== 3'd2 || bus.DstData !== 16'hAAAA || bus.DstReg !== 4'd5) begin
            errors++; $display("FAIL coll_first: got cnt=%0d reg=%0d data=%h want 2/5/aaaa",
                               bus.count, bus.DstReg, bus.DstData); end
        tick();
        checks++; if (bus.count !== 3'd1 || bus.DstData !== 16'h5555) begin errors++;
            $display("FAIL coll_second: got cnt=%0d data=%h want 1/5555", bus.count, bus.DstData); end
        tick();
        checks++; if (bus.WriteReg !== 1'b0 || rf[5] !== 16'h5555) begin errors++;
            $display("FAIL coll_final: got wr=%0b R5=%h want 0/5555", bus.WriteReg, rf[5]); end
    endtask

    task automatic test_fill_drain();
        logic [3:0]  exp_reg  [8];
        logic [15:0] exp_data [8];
        exp_reg  = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd6, 4'd0, 4'd0};
        exp_data = '{16'hA002, 16'hB002, 16'hA003, 16'hB003, 16'hC000, 16'hB003, 16'h0, 16'h0};
        for (int k = 1; k <= 3; k++) begin
            bus.mem_valid = 1'b1; bus.mem_reg = 4'(2*k-1); bus.mem_data = 16'hA000 + 16'(k);
            bus.alu_valid = 1'b1; bus.alu_reg = 4'(2*k);   bus.alu_data = 16'hB000 + 16'(k);
            #1;
            checks++; if (bus.alu_ready !== 1'b1) begin errors++;
                $display("FAIL fill_ready_%0d: got alu_ready=%0b want 1", k, bus.alu_ready); end
            tick();
            checks++; if (bus.count !== 3'(k+1)) begin errors++;
                $display("FAIL fill_count_%0d: got %0d want %0d", k, bus.count, k+1); end
        end
        // Full: mem keeps the only slot, ALU (6,B003) is held back.
        checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin errors++;
            $display("FAIL full_ready: got mem=%0b alu=%0b want 1/0", bus.mem_ready, bus.alu_ready); end
        bus.mem_reg = 4'd7; bus.mem_data = 16'hC000;
        tick();
        checks++; if (bus.count !== 3'd4 || bus.DstReg !== 4'd4 || bus.DstData !== 16'hB002) begin
            errors++; $display("FAIL full_mem: got cnt=%0d reg=%0d data=%h want 4/4/b002",
                               bus.count, bus.DstReg, bus.DstData); end
        bus.mem_valid = 1'b0;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++;
            $display("FAIL full_alu_ready: got %0b want 1", bus.alu_ready); end
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.WriteReg !== 1'b1 || bus.DstReg !== exp_reg[i+2]
                          || bus.DstData !== exp_data[i+2]) begin
                errors++; $display("FAIL drain_%0d: got wr=%0b reg=%0d data=%h want 1/%0d/%h", i,
                                   bus.WriteReg, bus.DstReg, bus.DstData, exp_reg[i+2], exp_data[i+2]);
            end
            tick();
        end
        checks++; if (bus.count !== 3'd0 || bus.WriteReg !== 1'b0) begin errors++;
            $display("FAIL drain_empty: got cnt=%0d wr=%0b want 0/0", bus.count, bus.WriteReg); end
        checks++; if (rf[6] !== 16'hB003 || rf[7] !== 16'hC000 || rf[3] !== 16'hA002) begin errors++;
            $display("FAIL drain_rf: got R3=%h R6=%h R7=%h want a002/b003/c000", rf[3], rf[6], rf[7]); end
    endtask

    task automatic test_reg0();
        bus.alu_valid = 1'b1; bus.alu_reg = 4'd0; bus.alu_data = 16'hFFFF;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++;
            $display("FAIL reg0_ready: got %0b want 1", bus.alu_ready); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.count !== 3'd0 || bus.WriteReg !== 1'b0) begin errors++;
            $display("FAIL reg0_drop: got cnt=%0d wr=%0b want 0/0", bus.count, bus.WriteReg); end
        bus.mem_valid = 1'b1; bus.mem_reg = 4'd0; bus.mem_data = 16'h1111;
        bus.alu_valid = 1'b1; bus.alu_reg = 4'd9; bus.alu_data = 16'h9999;
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.count !== 3'd1 || bus.DstReg !== 4'd9 || bus.DstData !== 16'h9999) begin
            errors++; $display("FAIL reg0_mix: got cnt=%0d reg=%0d data=%h want 1/9/9999",
                               bus.count, bus.DstReg, bus.DstData); end
        tick();
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 2; k++) begin
            bus.mem_valid = 1'b1; bus.mem_reg = 4'd10; bus.mem_data = 16'(k);
            bus.alu_valid = 1'b1; bus.alu_reg = 4'd11; bus.alu_data = 16'(k);
            tick();
        end
        idle_inputs();
        checks++; if (bus.count !== 3'd3) begin errors++;
            $display("FAIL mid_fill: got cnt=%0d want 3", bus.count); end
        rst_ni = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd0 || bus.WriteReg !== 1'b0) begin errors++;
            $display("FAIL mid_reset: got cnt=%0d wr=%0b want 0/0", bus.count, bus.WriteReg); end
        tick();
        rst_ni = 1'b1;
        tick();
        checks++; if (bus.count !== 3'd0 || bus.WriteReg !== 1'b0) begin errors++;
            $display("FAIL mid_after: got cnt=%0d wr=%0b want 0/0", bus.count, bus.WriteReg); end
    endtask

    task automatic test_lookup();
        bus.mem_valid = 1'b1; bus.mem_reg = 4'd7; bus.mem_data = 16'd1;
        bus.alu_valid = 1'b1; bus.alu_reg = 4'd7; bus.alu_data = 16'd2;
        tick();
        idle_inputs();
        bus.chk_reg = 4'd7;
        #1;
`ifdef RF_PEND_LOOKUP_EN
        checks++; if (bus.chk_pending !== 1'b1 || bus.chk_data !== 16'd2) begin errors++;
            $display("FAIL lookup_hit: got pend=%0b data=%h want 1/0002", bus.chk_pending, bus.chk_data); end
        bus.chk_reg = 4'd3;
        #1;
        checks++; if (bus.chk_pending !== 1'b0) begin errors++;
            $display("FAIL lookup_miss: got pend=%0b want 0", bus.chk_pending); end
`else
        checks++; if (bus.chk_pending !== 1'b0 || bus.chk_data !== 16'd0) begin errors++;
            $display("FAIL lookup_off: got pend=%0b data=%h want 0/0000", bus.chk_pending, bus.chk_data); end
`endif
        bus.chk_reg = '0;
        tick();
        tick();
        checks++; if (bus.count !== 3'd0 || rf[7] !== 16'd2) begin errors++;
            $display("FAIL lookup_drain: got cnt=%0d R7=%h want 0/0002", bus.count, rf[7]); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = '0;
        idle_inputs();
        bus.chk_reg = '0;
        test_reset();
        test_single_alu();
        test_collision();
        test_fill_drain();
        test_reg0();
        test_mid_reset();
        test_lookup();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
